// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM read/write port between instruction fetch
// (IF) and the load/store unit (LS). Each grant drives the RAM port for a single
// cycle. The read data is registered into a held response that is released
// through a valid/ready handshake.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [31:0]       if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_wen,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [DATA_W-1:0] ls_req_wmask,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [DATA_W-1:0] ls_rsp_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    output logic              mem_wen
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RSP = 2'd1,
        LS_RSP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_ls;      // 1 = the last grant went to LS
    logic [31:0]       r_if_rsp_data;
    logic [DATA_W-1:0] r_ls_rsp_rdata;
    logic              w_grant_if;
    logic              w_grant_ls;

    // Arbitration, RAM port drive and next-state logic. Grants are masked while
    // reset is held, so every output reads 0 as soon as reset is asserted.
    always_comb begin
        w_grant_if   = 1'b0;
        w_grant_ls   = 1'b0;
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wmask    = '0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    if (if_req_valid && ls_req_valid) begin
                        w_grant_if = r_last_ls;
                        w_grant_ls = !r_last_ls;
                    end else begin
                        w_grant_if = if_req_valid;
                        w_grant_ls = ls_req_valid;
                    end
                end
                if (w_grant_if) begin
                    mem_en       = 1'b1;
                    mem_addr     = if_req_addr;
                    w_next_state = IF_RSP;
                end else if (w_grant_ls) begin
                    mem_en       = 1'b1;
                    mem_addr     = ls_req_addr;
                    mem_wen      = ls_req_wen;
                    mem_wdata    = ls_req_wdata;
                    mem_wmask    = ls_req_wmask;
                    w_next_state = LS_RSP;
                end
            end
            IF_RSP: if (if_rsp_ready) w_next_state = IDLE;
            LS_RSP: if (ls_rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;
    assign if_rsp_valid = (r_state == IF_RSP);
    assign ls_rsp_valid = (r_state == LS_RSP);
    assign if_rsp_data  = r_if_rsp_data;
    assign ls_rsp_rdata = r_ls_rsp_rdata;

    // State register and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last_ls <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_grant_if)      r_last_ls <= 1'b0;
            else if (w_grant_ls) r_last_ls <= 1'b1;
        end
    end

    // Capture the response on the grant edge and hold it until the next grant.
    // Write acks return 0 rather than the pre-write RAM contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rsp_data  <= '0;
            r_ls_rsp_rdata <= '0;
        end else begin
            if (w_grant_if)
                r_if_rsp_data <= if_req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            if (w_grant_ls)
                r_ls_rsp_rdata <= ls_req_wen ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. All expected values are hand-computed.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic [31:0]       if_rsp_data;
    logic              ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid, ls_rsp_ready;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata, ls_req_wmask, ls_rsp_rdata;
    logic              mem_en, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata, mem_wdata, mem_wmask;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wen(mem_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        if_rsp_ready = 1'b0;
        ls_req_valid = 1'b1;
        ls_req_addr  = '0;
        ls_req_wen   = 1'b0;
        ls_req_wdata = '0;
        ls_req_wmask = '0;
        ls_rsp_ready = 1'b0;
        mem_rdata    = 64'h1122_3344_5566_7788;

        // Reset state: requests pending, but every output must read 0.
        step();
        #1;
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_ls_ready", ls_req_ready, 0);
        chk("rst_mem_en",   mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rsp_v", if_rsp_valid, 0);
        chk("rst_ls_rsp_v", ls_rsp_valid, 0);
        chk("rst_ls_rdata", ls_rsp_rdata, 0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset        = 1'b0;

        // Single IF read of the upper half.
        step();
        if_req_valid = 1'b1;
        #1;
        chk("if_ready",    if_req_ready, 1);
        chk("if_ls_ready", ls_req_ready, 0);
        chk("if_mem_en",   mem_en, 1);
        chk("if_mem_addr", mem_addr, 64'h8000_0004);
        chk("if_mem_wen",  mem_wen, 0);
        chk("if_mem_mask", mem_wmask, 0);
        step();
        if_req_valid = 1'b0;
        #1;
        chk("if_rsp_v",    if_rsp_valid, 1);
        chk("if_rsp_data", if_rsp_data, 64'h1122_3344);
        chk("if_rsp_men",  mem_en, 0);
        if_rsp_ready = 1'b1;
        step();
        chk("if_rsp_done", if_rsp_valid, 0);

        // Single IF read of the lower half.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        step();
        if_req_valid = 1'b0;
        chk("if_lo_data", if_rsp_data, 64'h5566_7788);
        step();

        // A reset pulse restores last_grant, so the first tie goes to IF.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        if_req_addr  = 64'h8000_0004;
        ls_req_addr  = 64'h8000_0008;
        ls_rsp_ready = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("tie%0d_if_ready", k), if_req_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("tie%0d_ls_ready", k), ls_req_ready, (k % 2 == 0) ? 0 : 1);
            chk($sformatf("tie%0d_addr", k), mem_addr,
                (k % 2 == 0) ? 64'h8000_0004 : 64'h8000_0008);
            step();
            if (k % 2 == 0) chk($sformatf("tie%0d_rsp", k), if_rsp_valid, 1);
            else            chk($sformatf("tie%0d_rsp", k), ls_rsp_rdata, 64'h1122_3344_5566_7788);
            step();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // LS write, followed by a held write ack while IF is waiting.
        ls_rsp_ready = 1'b0;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b1;
        ls_req_addr  = 64'h8000_0010;
        ls_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        ls_req_wmask = 64'h0000_0000_FFFF_FFFF;
        #1;
        chk("wr_mem_wen",   mem_wen, 1);
        chk("wr_mem_addr",  mem_addr, 64'h8000_0010);
        chk("wr_mem_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("wr_mem_wmask", mem_wmask, 64'h0000_0000_FFFF_FFFF);
        step();
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1;
        #1;
        chk("wr_wen_once", mem_wen, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_ls_v", k), ls_rsp_valid, 1);
            chk($sformatf("hold%0d_rdata", k), ls_rsp_rdata, 0);
            chk($sformatf("hold%0d_if_rdy", k), if_req_ready, 0);
            chk($sformatf("hold%0d_mem_en", k), mem_en, 0);
            step();
        end
        ls_rsp_ready = 1'b1;
        step();
        chk("hold_if_grant", if_req_ready, 1);
        chk("hold_ls_v_off", ls_rsp_valid, 0);

        // Reset while IF_RSP is pending, then a clean LS read.
        if_rsp_ready = 1'b0;
        step();
        if_req_valid = 1'b0;
        chk("pre_rst_if_v", if_rsp_valid, 1);
        reset = 1'b1;
        #1;
        chk("midrst_if_v",    if_rsp_valid, 0);
        chk("midrst_if_data", if_rsp_data, 0);
        step();
        reset        = 1'b0;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h8000_0020;
        mem_rdata    = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("post_ls_ready", ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0;
        chk("post_ls_v",     ls_rsp_valid, 1);
        chk("post_ls_rdata", ls_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
